riscv_ctrl_branch_pred: RTL

Parametrised branch resolution and prediction unit for the RISC-V control path. It sits between fetch and execute:
- **Fetch side:** predicts taken/not-taken per PC from a table of 2-bit saturating counters (BHT).
- **Execute side:** resolves branches by comparing XLEN-wide operands directly, flags mispredictions, trains the BHT and keeps saturating statistics counters.

It supersedes flag-based jump decoding in the control path.

---
 rtl/riscv_ctrl_pkg.sv | 31 +++
 rtl/riscv_ctrl_brcmp.sv | 36 +++
 rtl/riscv_ctrl_branch_pred.sv | 100 ++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared control-path constants: opcodes, branch funct3 encodings and BHT
// counter helpers used by the branch resolution/prediction unit.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Weakly not-taken.
    localparam logic [1:0] BHT_INIT = 2'b01;

    typedef struct packed {
        logic valid;
        logic taken;
        logic mispredict;
        logic illegal;
    } resolve_t;

    function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/riscv_ctrl_brcmp.sv
// Combinational branch comparator: decides taken/illegal for an execute-stage op
// straight from the operands.
module riscv_ctrl_brcmp
    import riscv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [6:0]      op,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_BRANCH: begin
                case (funct3)
                    F3_BEQ:  taken = (rs1 == rs2);
                    F3_BNE:  taken = (rs1 != rs2);
                    F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
                    F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
                    F3_BLTU: taken = (rs1 <  rs2);
                    F3_BGEU: taken = (rs1 >= rs2);
                    default: illegal = 1'b1;
                endcase
            end
            OP_JAL, OP_JALR: taken = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_ctrl_branch_pred.sv
// Branch prediction (2-bit BHT lookup at fetch) and resolution (compare,
// mispredict flag, BHT training, saturating statistics) at execute.
module riscv_ctrl_branch_pred
    import riscv_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 16
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             ifetch_valid,
    input  logic [XLEN-1:0]  ifetch_pc,
    output logic             opred_valid,
    output logic             opred_taken,
    input  logic             iex_valid,
    input  logic [6:0]       iex_op,
    input  logic [2:0]       iex_funct3,
    input  logic [XLEN-1:0]  iex_pc,
    input  logic [XLEN-1:0]  iex_rs1,
    input  logic [XLEN-1:0]  iex_rs2,
    input  logic             iex_pred_taken,
    output logic             oresolve_valid,
    output logic             opc_src,
    output logic             omispredict,
    output logic             oillegal,
    input  logic             iclr_stats,
    output logic [CNT_W-1:0] obr_count,
    output logic [CNT_W-1:0] omiss_count
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] fetch_idx, upd_idx;
    logic             taken, illegal, cond_br, miss;
    resolve_t         res_q;

    riscv_ctrl_brcmp #(.XLEN(XLEN)) u_brcmp (
        .op      (iex_op),
        .funct3  (iex_funct3),
        .rs1     (iex_rs1),
        .rs2     (iex_rs2),
        .taken   (taken),
        .illegal (illegal)
    );

    assign fetch_idx = ifetch_pc[IDX_W+1:2];
    assign upd_idx   = iex_pc[IDX_W+1:2];
    assign cond_br   = iex_valid && (iex_op == OP_BRANCH) && !illegal;
    assign miss      = iex_valid && (taken ^ iex_pred_taken);

    logic unused_pc_bits;
    assign unused_pc_bits = ^{ifetch_pc[XLEN-1:IDX_W+2], ifetch_pc[1:0],
                              iex_pc[XLEN-1:IDX_W+2], iex_pc[1:0]};

    // Flop array rather than RAM: every entry must return to weakly not-taken on reset.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= BHT_INIT;
        end else if (cond_br) begin
            bht[upd_idx] <= bht_next(bht[upd_idx], taken);
        end
    end

    // Lookup reads the pre-edge array, so a same-cycle update is not forwarded.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            opred_valid <= 1'b0;
            opred_taken <= 1'b0;
            res_q       <= '0;
        end else begin
            opred_valid <= ifetch_valid;
            opred_taken <= ifetch_valid & bht[fetch_idx][1];
            res_q       <= '{valid:      iex_valid,
                             taken:      iex_valid & taken,
                             mispredict: miss,
                             illegal:    iex_valid & illegal};
        end
    end

    assign oresolve_valid = res_q.valid;
    assign opc_src        = res_q.taken;
    assign omispredict    = res_q.mispredict;
    assign oillegal       = res_q.illegal;

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            obr_count   <= '0;
            omiss_count <= '0;
        end else if (iclr_stats) begin
            obr_count   <= '0;
            omiss_count <= '0;
        end else begin
            if (cond_br && !(&obr_count))  obr_count   <= obr_count + CNT_W'(1);
            if (miss && !(&omiss_count))   omiss_count <= omiss_count + CNT_W'(1);
        end
    end

endmodule
